// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and the hex-to-segment encoder for the
//                7-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment bit positions within a 7-bit pattern (bit6..bit0 = g..a)
    localparam int SEG_IDX_A = 0;
    localparam int SEG_IDX_B = 1;
    localparam int SEG_IDX_C = 2;
    localparam int SEG_IDX_D = 3;
    localparam int SEG_IDX_E = 4;
    localparam int SEG_IDX_F = 5;
    localparam int SEG_IDX_G = 6;

    // Active-high segment patterns
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Blink phase: SHOW lights masked digits, HIDE blanks them
    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_e;

    // Digit value to active-high segment pattern; 10..14 blank, 15 dash
    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            4'd15:   pat = SEG_DASH;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational digit decoder with output polarity applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode #(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    import seg7_pkg::*;

    localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    // Encode the nibble and flip to the pad polarity
    always_comb begin
        o_seg = seg7_encode(i_nibble) ^ SEG_INV;
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed 7-segment driver with per-slot dead time,
//                frame-aligned input snapshot and digit blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    input  logic                    i_blink_tick,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_dig,
    output logic                    o_frame
);
    import seg7_pkg::*;

    localparam int PW = $clog2(SCAN_DIV);
    localparam int SW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);

    // Pad-level "off" values
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    // Scan state
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] slot_q, slot_d;
    blink_e        blink_q, blink_d;

    // Frame snapshot of the display inputs
    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]      mask_q, mask_d;

    // Registered outputs
    logic [6:0]            seg_q, seg_d;
    logic                  odp_q, odp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_q, frame_d;

    logic                  presc_wrap;
    logic                  frame_wrap;
    logic                  dark;
    logic [NUM_DIGITS-1:0] dig_onehot;
    logic [6:0]            dec_seg;

    seg7_decode #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_decode (
        .i_nibble (digits_q[slot_q]),
        .o_seg    (dec_seg)
    );

    // Prescaler, slot counter and snapshot next-state; disabled scan parks at 0
    // and keeps the snapshot tracking the inputs so a restart shows fresh values
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        frame_wrap = i_en && presc_wrap && (slot_q == SLOT_LAST);
        presc_d    = presc_q;
        slot_d     = slot_q;
        digits_d   = digits_q;
        dp_d       = dp_q;
        mask_d     = mask_q;
        frame_d    = frame_wrap;
        if (!i_en) begin
            presc_d  = '0;
            slot_d   = '0;
            digits_d = i_digits;
            dp_d     = i_dp;
            mask_d   = i_blink_mask;
        end else begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end
            if (frame_wrap) begin
                digits_d = i_digits;
                dp_d     = i_dp;
                mask_d   = i_blink_mask;
            end
        end
    end

    // Blink phase toggles on each tick while scanning, forced to SHOW when idle
    always_comb begin
        blink_d = blink_q;
        if (!i_en) begin
            blink_d = BLINK_SHOW;
        end else if (i_blink_tick) begin
            blink_d = (blink_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
        end
    end

    // Output stage: dark during dead time, when disabled, or for a blinked-off digit
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dig_onehot[k] = (slot_q == SW'(k));
        end
        dark = !i_en || (presc_q < BLANK_END) ||
               ((blink_q == BLINK_HIDE) && mask_q[slot_q]);
        if (dark) begin
            seg_d = SEG_OFF;
            odp_d = DP_OFF;
            dig_d = DIG_OFF;
        end else begin
            seg_d = dec_seg;
            odp_d = dp_q[slot_q] ^ DP_OFF;
            dig_d = dig_onehot ^ DIG_OFF;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q  <= '0;
            slot_q   <= '0;
            blink_q  <= BLINK_SHOW;
            digits_q <= '0;
            dp_q     <= '0;
            mask_q   <= '0;
            seg_q    <= SEG_OFF;
            odp_q    <= DP_OFF;
            dig_q    <= DIG_OFF;
            frame_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            slot_q   <= slot_d;
            blink_q  <= blink_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            mask_q   <= mask_d;
            seg_q    <= seg_d;
            odp_q    <= odp_d;
            dig_q    <= dig_d;
            frame_q  <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = odp_q;
    assign o_dig   = dig_q;
    assign o_frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver (4 digits, 8-cycle
//                slots, 2 dead cycles, active-low pads).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        tick;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_dig;
    logic        o_frame;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (DIV),
        .BLANK_CYC      (BLK),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_digits     (digits),
        .i_dp         (dp),
        .i_blink_mask (mask),
        .i_blink_tick (tick),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_dig        (o_dig),
        .o_frame      (o_frame)
    );

    int total = 0;
    int bad   = 0;

    // Active-high glyphs for 0..F
    logic [6:0] glyph [16];

    // Reference model: position within the frame counted from enable
    int          m_t;
    bit          m_phase;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic [3:0]  m_mask;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_dig;
    logic        e_frame;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        int          slot;
        logic [3:0]  dig;
        logic [6:0]  seg;
        logic        odp;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_phase = 0; m_digits = '0; m_dp = '0; m_mask = '0;
        e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_frame = 1'b0;
    endtask

    // One clock: advance model with the inputs seen at the edge, then compare
    task automatic step();
        int pos, sl, pr;
        @(posedge clk);
        pos = m_t % FRAME;
        sl  = pos / DIV;
        pr  = pos % DIV;
        if (!en || pr < BLK || (m_phase && m_mask[sl])) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
        end else begin
            e_dig = ~(4'b0001 << sl);
            e_seg = ~glyph[m_digits[sl*4 +: 4]];
            e_dp  = ~m_dp[sl];
        end
        e_frame = en && (pos == FRAME - 1);
        if (!en) begin
            m_digits = digits; m_dp = dp; m_mask = mask;
            m_t = 0; m_phase = 0;
        end else begin
            if (pos == FRAME - 1) begin
                m_digits = digits; m_dp = dp; m_mask = mask;
            end
            m_t++;
            if (tick) m_phase = !m_phase;
        end
        #1;
        chk("seg",   {9'd0, o_seg},    {9'd0, e_seg});
        chk("dig",   {12'd0, o_dig},   {12'd0, e_dig});
        chk("dp",    {15'd0, o_dp},    {15'd0, e_dp});
        chk("frame", {15'd0, o_frame}, {15'd0, e_frame});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt_e, cnt_d;

        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
        glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
        glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h00; glyph[11] = 7'h00;
        glyph[12] = 7'h00; glyph[13] = 7'h00; glyph[14] = 7'h00; glyph[15] = 7'h40;

        vecs[0]  = '{16'h1234, 4'b0000, 0, 4'hE, 7'h19, 1'b1};
        vecs[1]  = '{16'h1234, 4'b0000, 1, 4'hD, 7'h30, 1'b1};
        vecs[2]  = '{16'h1234, 4'b0000, 2, 4'hB, 7'h24, 1'b1};
        vecs[3]  = '{16'h1234, 4'b0000, 3, 4'h7, 7'h79, 1'b1};
        vecs[4]  = '{16'hFAF0, 4'b0010, 0, 4'hE, 7'h40, 1'b1};
        vecs[5]  = '{16'hFAF0, 4'b0010, 1, 4'hD, 7'h3F, 1'b0};
        vecs[6]  = '{16'hFAF0, 4'b0010, 2, 4'hB, 7'h7F, 1'b1};
        vecs[7]  = '{16'hFAF0, 4'b0010, 3, 4'h7, 7'h3F, 1'b1};
        vecs[8]  = '{16'h0789, 4'b1001, 0, 4'hE, 7'h10, 1'b0};
        vecs[9]  = '{16'h0789, 4'b1001, 1, 4'hD, 7'h00, 1'b1};
        vecs[10] = '{16'h0789, 4'b1001, 2, 4'hB, 7'h78, 1'b1};
        vecs[11] = '{16'h0789, 4'b1001, 3, 4'h7, 7'h40, 1'b0};

        rst_n = 1'b1; en = 1'b0; digits = '0; dp = '0; mask = '0; tick = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_seg",   {9'd0, o_seg},    16'h007F);
        chk("reset_dig",   {12'd0, o_dig},   16'h000F);
        chk("reset_dp",    {15'd0, o_dp},    16'h0001);
        chk("reset_frame", {15'd0, o_frame}, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        steps(3);

        // Table-driven glyph / digit / dp checks
        for (int v = 0; v < 12; v++) begin
            en = 1'b0; digits = vecs[v].digits; dp = vecs[v].dp; mask = '0;
            steps(2);
            en = 1'b1;
            steps(vecs[v].slot * DIV + 5);
            chk("vec_dig", {12'd0, o_dig}, {12'd0, vecs[v].dig});
            chk("vec_seg", {9'd0, o_seg},  {9'd0, vecs[v].seg});
            chk("vec_dp",  {15'd0, o_dp},  {15'd0, vecs[v].odp});
        end

        // Reset asserted mid-scan takes effect without a clock edge
        en = 1'b0; digits = 16'h1234; dp = '0; steps(1);
        en = 1'b1; steps(13);
        #3 rst_n = 1'b0;
        #1;
        chk("midscan_rst_seg",   {9'd0, o_seg},    16'h007F);
        chk("midscan_rst_dig",   {12'd0, o_dig},   16'h000F);
        chk("midscan_rst_dp",    {15'd0, o_dp},    16'h0001);
        chk("midscan_rst_frame", {15'd0, o_frame}, 16'h0000);
        model_reset();
        en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        steps(3);

        // Tear-free: inputs change in slot 1, old frame keeps showing
        en = 1'b0; digits = 16'h1234; steps(1);
        en = 1'b1; steps(11);
        digits = 16'h5678;
        steps(18);
        chk("tear_slot3_seg", {9'd0, o_seg}, 16'h0079);
        steps(3);
        chk("tear_frame_pulse", {15'd0, o_frame}, 16'h0001);
        steps(3);
        chk("tear_new_slot0", {9'd0, o_seg}, 16'h0000);

        // Blink: digit 0 hidden for a frame, then restored
        en = 1'b0; digits = 16'h1234; mask = 4'b0001; steps(1);
        en = 1'b1; tick = 1'b1; step(); tick = 1'b0;
        cnt_e = 0; cnt_d = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (o_dig == 4'hE) cnt_e++;
            if (o_dig == 4'hD) cnt_d++;
        end
        chk("blink_hidden_d0", 16'(cnt_e), 16'd0);
        chk("blink_d1_lit",    16'(cnt_d), 16'(DIV - BLK));
        tick = 1'b1; step(); tick = 1'b0;
        cnt_e = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (o_dig == 4'hE) cnt_e++;
        end
        chk("blink_restored_d0", 16'(cnt_e), 16'(DIV - BLK));
        mask = '0;

        // Enable drop in slot 2 cycle 5, re-raise after 3 cycles
        en = 1'b0; digits = 16'h1234; steps(1);
        en = 1'b1; steps(21);
        en = 1'b0; step();
        chk("en_drop_dark", {12'd0, o_dig}, 16'h000F);
        steps(2);
        en = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (o_dig != 4'hE && n < 12);
        chk("en_restart_latency", 16'(n), 16'd3);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) en = !en;
            tick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0)  digits = 16'($urandom);
            if ($urandom_range(0, 39) == 0) dp     = 4'($urandom);
            if ($urandom_range(0, 39) == 0) mask   = 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
